// File: rtl/cdb_arbiter_if.sv
// cdb_arbiter_if: bundle of the result-producer handshakes and the common data
// bus broadcast shared between the ALU, the LSB and the CDB arbiter.
//   alu_valid/alu_rob_pos/alu_val  ALU result push        (producer -> arbiter)
//   alu_full                       ALU FIFO full           (arbiter -> producer)
//   lsb_valid/lsb_rob_pos/lsb_val  load result push       (producer -> arbiter)
//   lsb_full                       LSB FIFO full           (arbiter -> producer)
//   cdb_valid/cdb_rob_pos/cdb_val  broadcast result        (arbiter -> snoopers)
//   cdb_src                        0 = ALU, 1 = LSB        (arbiter -> snoopers)
//   overflow                       sticky push-while-full  (arbiter -> anyone)
// master = producer/snooper side, slave = arbiter side.
interface cdb_arbiter_if #(
   parameter int ROB_W  = 4,
   parameter int DATA_W = 32
);
   logic              alu_valid;
   logic [ROB_W-1:0]  alu_rob_pos;
   logic [DATA_W-1:0] alu_val;
   logic              alu_full;
   logic              lsb_valid;
   logic [ROB_W-1:0]  lsb_rob_pos;
   logic [DATA_W-1:0] lsb_val;
   logic              lsb_full;
   logic              cdb_valid;
   logic [ROB_W-1:0]  cdb_rob_pos;
   logic [DATA_W-1:0] cdb_val;
   logic              cdb_src;
   logic              overflow;

   modport master (
      output alu_valid, alu_rob_pos, alu_val,
      output lsb_valid, lsb_rob_pos, lsb_val,
      input  alu_full, lsb_full,
      input  cdb_valid, cdb_rob_pos, cdb_val, cdb_src, overflow
   );

   modport slave (
      input  alu_valid, alu_rob_pos, alu_val,
      input  lsb_valid, lsb_rob_pos, lsb_val,
      output alu_full, lsb_full,
      output cdb_valid, cdb_rob_pos, cdb_val, cdb_src, overflow
   );
endinterface

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: shares the single common data bus between the ALU and the LSB
// load-result producers. Each source owns a DEPTH-entry in-order FIFO that
// absorbs collisions; one result is broadcast per cycle, with round-robin
// arbitration on ties. Flushed by rollback, frozen while rdy is low.
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   rdy       global ready; low holds every register
//   rollback  misprediction flush of both FIFOs
//   bus       cdb_arbiter_if.slave (producer pushes, full flags, CDB outputs)
// All outputs are registered; there is no input-to-output combinational path.
module cdb_arbiter #(
   parameter int DEPTH  = 4,
   parameter int ROB_W  = 4,
   parameter int DATA_W = 32
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           rdy,
   input  logic           rollback,
   cdb_arbiter_if.slave   bus
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   typedef enum logic {
      SRC_ALU = 1'b0,
      SRC_LSB = 1'b1
   } src_e;

   typedef struct packed {
      logic [ROB_W-1:0]  rob_pos;
      logic [DATA_W-1:0] val;
   } entry_t;

   // FIFO storage and bookkeeping
   entry_t           alu_mem [DEPTH];
   entry_t           lsb_mem [DEPTH];
   logic [PTR_W-1:0] alu_rd, alu_wr, lsb_rd, lsb_wr;
   logic [CNT_W-1:0] alu_cnt, lsb_cnt;

   // arbitration state
   src_e             last_grant, last_grant_nx;

   // registered outputs
   logic              cdb_valid_q;
   logic [ROB_W-1:0]  cdb_rob_pos_q;
   logic [DATA_W-1:0] cdb_val_q;
   src_e              cdb_src_q;
   logic              alu_full_q, lsb_full_q, overflow_q;

   // combinational decision signals
   entry_t           alu_in, lsb_in;
   entry_t           alu_cand, lsb_cand, gnt_entry;
   logic             alu_cand_v, lsb_cand_v;
   logic             alu_head_v, lsb_head_v;
   logic             gnt_v;
   src_e             gnt_src;
   logic             alu_win, lsb_win;
   logic             alu_pop, lsb_pop;
   logic             alu_direct, lsb_direct;
   logic             alu_push, lsb_push;
   logic             alu_drop, lsb_drop;
   logic [CNT_W-1:0] alu_cnt_nx, lsb_cnt_nx;

   always_comb begin
      alu_in        = '{rob_pos: bus.alu_rob_pos, val: bus.alu_val};
      lsb_in        = '{rob_pos: bus.lsb_rob_pos, val: bus.lsb_val};

      // A non-empty FIFO always presents its head; an incoming push may only
      // be a candidate when its own FIFO is empty, which preserves order.
      alu_head_v    = (alu_cnt != '0);
      lsb_head_v    = (lsb_cnt != '0);
      alu_cand      = alu_head_v ? alu_mem[alu_rd] : alu_in;
      lsb_cand      = lsb_head_v ? lsb_mem[lsb_rd] : lsb_in;
      alu_cand_v    = alu_head_v || bus.alu_valid;
      lsb_cand_v    = lsb_head_v || bus.lsb_valid;

      gnt_v         = alu_cand_v || lsb_cand_v;
      gnt_src       = last_grant;
      if (alu_cand_v && lsb_cand_v) begin
         gnt_src = (last_grant == SRC_LSB) ? SRC_ALU : SRC_LSB;
      end else if (alu_cand_v) begin
         gnt_src = SRC_ALU;
      end else if (lsb_cand_v) begin
         gnt_src = SRC_LSB;
      end
      gnt_entry     = (gnt_src == SRC_ALU) ? alu_cand : lsb_cand;
      last_grant_nx = gnt_v ? gnt_src : last_grant;

      alu_win       = gnt_v && (gnt_src == SRC_ALU);
      lsb_win       = gnt_v && (gnt_src == SRC_LSB);
      alu_pop       = alu_win && alu_head_v;
      lsb_pop       = lsb_win && lsb_head_v;
      alu_direct    = alu_win && !alu_head_v;
      lsb_direct    = lsb_win && !lsb_head_v;

      // Acceptance looks at the pre-edge count: a simultaneous pop does not
      // make room for a push that arrives while full.
      alu_push      = bus.alu_valid && !alu_direct && (alu_cnt != FULL_CNT);
      lsb_push      = bus.lsb_valid && !lsb_direct && (lsb_cnt != FULL_CNT);
      alu_drop      = bus.alu_valid && !alu_direct && (alu_cnt == FULL_CNT);
      lsb_drop      = bus.lsb_valid && !lsb_direct && (lsb_cnt == FULL_CNT);

      alu_cnt_nx    = alu_cnt + CNT_W'(alu_push) - CNT_W'(alu_pop);
      lsb_cnt_nx    = lsb_cnt + CNT_W'(lsb_push) - CNT_W'(lsb_pop);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_rd        <= '0;
         alu_wr        <= '0;
         alu_cnt       <= '0;
         lsb_rd        <= '0;
         lsb_wr        <= '0;
         lsb_cnt       <= '0;
         last_grant    <= SRC_LSB;
         cdb_valid_q   <= 1'b0;
         cdb_rob_pos_q <= '0;
         cdb_val_q     <= '0;
         cdb_src_q     <= SRC_ALU;
         alu_full_q    <= 1'b0;
         lsb_full_q    <= 1'b0;
         overflow_q    <= 1'b0;
      end else if (rdy) begin
         if (rollback) begin
            alu_rd      <= '0;
            alu_wr      <= '0;
            alu_cnt     <= '0;
            lsb_rd      <= '0;
            lsb_wr      <= '0;
            lsb_cnt     <= '0;
            cdb_valid_q <= 1'b0;
            alu_full_q  <= 1'b0;
            lsb_full_q  <= 1'b0;
         end else begin
            if (alu_push) alu_wr <= alu_wr + 1'b1;
            if (alu_pop)  alu_rd <= alu_rd + 1'b1;
            if (lsb_push) lsb_wr <= lsb_wr + 1'b1;
            if (lsb_pop)  lsb_rd <= lsb_rd + 1'b1;
            alu_cnt     <= alu_cnt_nx;
            lsb_cnt     <= lsb_cnt_nx;
            alu_full_q  <= (alu_cnt_nx == FULL_CNT);
            lsb_full_q  <= (lsb_cnt_nx == FULL_CNT);
            overflow_q  <= overflow_q || alu_drop || lsb_drop;
            last_grant  <= last_grant_nx;
            cdb_valid_q <= gnt_v;
            if (gnt_v) begin
               cdb_rob_pos_q <= gnt_entry.rob_pos;
               cdb_val_q     <= gnt_entry.val;
               cdb_src_q     <= gnt_src;
            end
         end
      end
   end

   // Storage needs no reset: counts gate every read.
   always_ff @(posedge clk) begin
      if (rdy && !rollback) begin
         if (alu_push) alu_mem[alu_wr] <= alu_in;
         if (lsb_push) lsb_mem[lsb_wr] <= lsb_in;
      end
   end

   assign bus.cdb_valid   = cdb_valid_q;
   assign bus.cdb_rob_pos = cdb_rob_pos_q;
   assign bus.cdb_val     = cdb_val_q;
   assign bus.cdb_src     = cdb_src_q;
   assign bus.alu_full    = alu_full_q;
   assign bus.lsb_full    = lsb_full_q;
   assign bus.overflow    = overflow_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed and randomized stimulus for cdb_arbiter, checked
// against a queue-based reference model of the arbitration rules.
module tb_cdb_arbiter;
   localparam int DEPTH  = 4;
   localparam int ROB_W  = 4;
   localparam int DATA_W = 32;

   logic clk = 1'b0;
   logic rst_n, rdy, rollback;

   cdb_arbiter_if #(.ROB_W(ROB_W), .DATA_W(DATA_W)) bus ();

   cdb_arbiter #(.DEPTH(DEPTH), .ROB_W(ROB_W), .DATA_W(DATA_W)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .rdy      (rdy),
      .rollback (rollback),
      .bus      (bus)
   );

   always #5 clk = ~clk;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   // reference model state: entries are {rob_pos, val}
   logic [35:0] m_aq[$];
   logic [35:0] m_lq[$];
   logic        m_last, m_ovf, m_valid, m_src, m_afull, m_lfull;
   logic [3:0]  m_pos;
   logic [31:0] m_val;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_aq.delete();
      m_lq.delete();
      m_last  = 1'b1;
      m_ovf   = 1'b0;
      m_valid = 1'b0;
      m_src   = 1'b0;
      m_afull = 1'b0;
      m_lfull = 1'b0;
      m_pos   = '0;
      m_val   = '0;
   endtask

   task automatic model_edge(input logic r, input logic rb,
                             input logic av, input logic [35:0] ae,
                             input logic lv, input logic [35:0] le);
      int unsigned asz, lsz;
      logic a_c, l_c, has_g, g;
      logic [35:0] e;
      if (!r) return;
      if (rb) begin
         m_aq.delete();
         m_lq.delete();
         m_valid = 1'b0;
         m_afull = 1'b0;
         m_lfull = 1'b0;
         return;
      end
      asz   = m_aq.size();
      lsz   = m_lq.size();
      a_c   = (asz > 0) || av;
      l_c   = (lsz > 0) || lv;
      has_g = a_c || l_c;
      g     = (a_c && l_c) ? !m_last : l_c;
      m_valid = has_g;
      if (has_g) begin
         if (g) e = (lsz > 0) ? m_lq[0] : le;
         else   e = (asz > 0) ? m_aq[0] : ae;
         m_pos  = e[35:32];
         m_val  = e[31:0];
         m_src  = g;
         m_last = g;
      end
      if (has_g && !g && asz > 0) void'(m_aq.pop_front());
      if (has_g &&  g && lsz > 0) void'(m_lq.pop_front());
      if (av && !(has_g && !g && asz == 0)) begin
         if (asz < DEPTH) m_aq.push_back(ae);
         else             m_ovf = 1'b1;
      end
      if (lv && !(has_g && g && lsz == 0)) begin
         if (lsz < DEPTH) m_lq.push_back(le);
         else             m_ovf = 1'b1;
      end
      m_afull = (m_aq.size() == DEPTH);
      m_lfull = (m_lq.size() == DEPTH);
   endtask

   task automatic check_outputs();
      chk("cdb_valid", bus.cdb_valid, m_valid);
      if (m_valid) begin
         chk("cdb_rob_pos", bus.cdb_rob_pos, m_pos);
         chk("cdb_val",     bus.cdb_val,     m_val);
         chk("cdb_src",     bus.cdb_src,     m_src);
      end
      chk("alu_full", bus.alu_full, m_afull);
      chk("lsb_full", bus.lsb_full, m_lfull);
      chk("overflow", bus.overflow, m_ovf);
   endtask

   // One clock: drive inputs, advance the model at the edge, compare after it.
   task automatic cyc(input logic r, input logic rb,
                      input logic av, input logic [3:0] ap, input logic [31:0] ad,
                      input logic lv, input logic [3:0] lp, input logic [31:0] ld);
      rdy             = r;
      rollback        = rb;
      bus.alu_valid   = av;
      bus.alu_rob_pos = ap;
      bus.alu_val     = ad;
      bus.lsb_valid   = lv;
      bus.lsb_rob_pos = lp;
      bus.lsb_val     = ld;
      @(posedge clk);
      model_edge(r, rb, av, {ap, ad}, lv, {lp, ld});
      #1;
      check_outputs();
   endtask

   task automatic idle(input int unsigned n);
      for (int unsigned i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
   endtask

   task automatic check_reset_values();
      chk("rst_cdb_valid", bus.cdb_valid, 1'b0);
      chk("rst_cdb_rob_pos", bus.cdb_rob_pos, 4'd0);
      chk("rst_cdb_val", bus.cdb_val, 32'd0);
      chk("rst_cdb_src", bus.cdb_src, 1'b0);
      chk("rst_alu_full", bus.alu_full, 1'b0);
      chk("rst_lsb_full", bus.lsb_full, 1'b0);
      chk("rst_overflow", bus.overflow, 1'b0);
   endtask

   initial begin
      rst_n = 1'b0;
      rdy = 1'b1;
      rollback = 1'b0;
      bus.alu_valid = 1'b0; bus.alu_rob_pos = '0; bus.alu_val = '0;
      bus.lsb_valid = 1'b0; bus.lsb_rob_pos = '0; bus.lsb_val = '0;
      model_reset();
      #12;
      check_reset_values();
      @(negedge clk);
      rst_n = 1'b1;
      idle(2);

      // single uncontended push: visible next cycle, gone the cycle after
      cyc(1, 0, 1, 4'd3, 32'h11, 0, 4'd0, 32'd0);
      chk("single_valid", bus.cdb_valid, 1'b1);
      chk("single_pos", bus.cdb_rob_pos, 4'd3);
      chk("single_val", bus.cdb_val, 32'h11);
      chk("single_src", bus.cdb_src, 1'b0);
      idle(1);
      chk("single_gone", bus.cdb_valid, 1'b0);

      // make LSB the last grant, then a tie goes to ALU first
      cyc(1, 0, 0, 4'd0, 32'd0, 1, 4'd9, 32'h99);
      cyc(1, 0, 1, 4'd1, 32'hA, 1, 4'd2, 32'hB);
      chk("tie1_pos", bus.cdb_rob_pos, 4'd1);
      chk("tie1_src", bus.cdb_src, 1'b0);
      cyc(1, 0, 1, 4'd5, 32'hC, 0, 4'd0, 32'd0);
      chk("tie2_pos", bus.cdb_rob_pos, 4'd2);
      chk("tie2_src", bus.cdb_src, 1'b1);
      idle(1);
      chk("tie3_pos", bus.cdb_rob_pos, 4'd5);
      chk("tie3_src", bus.cdb_src, 1'b0);
      idle(2);

      // fill/overflow: both sources push every cycle, ALU ignoring full
      for (int unsigned i = 0; i < 12; i++)
         cyc(1, 0, 1, 4'(i), 32'h100 + i, 1, 4'(i + 8), 32'h200 + i);
      chk("ovf_sticky", bus.overflow, 1'b1);
      idle(20);

      // rollback with queued entries and a concurrent push
      for (int unsigned i = 0; i < 5; i++)
         cyc(1, 0, 1, 4'(i), 32'h300 + i, 1, 4'(i + 4), 32'h400 + i);
      cyc(1, 1, 1, 4'hF, 32'hDEAD, 0, 4'd0, 32'd0);
      chk("rb_valid", bus.cdb_valid, 1'b0);
      idle(4);

      // stall: rdy low with pushes, then drain
      for (int unsigned i = 0; i < 4; i++)
         cyc(1, 0, 1, 4'(i), 32'h500 + i, 1, 4'(i + 6), 32'h600 + i);
      for (int unsigned i = 0; i < 3; i++)
         cyc(0, 0, 1, 4'hE, 32'hBAD0 + i, 1, 4'hD, 32'hBAD8 + i);
      idle(10);

      // asynchronous reset mid-cycle with queued entries
      for (int unsigned i = 0; i < 3; i++)
         cyc(1, 0, 1, 4'(i), 32'h700 + i, 1, 4'(i + 3), 32'h800 + i);
      #3;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_reset_values();
      @(negedge clk);
      rst_n = 1'b1;
      idle(4);

      // randomized traffic
      for (int unsigned i = 0; i < 600; i++) begin
         logic r, rb, av, lv;
         r  = ($urandom_range(0, 9) != 0);
         rb = ($urandom_range(0, 39) == 0);
         av = ($urandom_range(0, 1) == 1) && (!bus.alu_full || $urandom_range(0, 15) == 0);
         lv = ($urandom_range(0, 1) == 1) && (!bus.lsb_full || $urandom_range(0, 15) == 0);
         cyc(r, rb, av, 4'($urandom), $urandom, lv, 4'($urandom), $urandom);
      end
      idle(12);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
